// File: rtl/powerup_spawn_scheduler.sv
// powerup_spawn_scheduler: paces powerup spawns with a frame-tick cooldown,
// draws candidate tiles from a free-running 16-bit Galois LFSR, probes the
// maze wall map through a registered read port, retries on walls and hands
// a spawn command for the lowest free slot to the powerup manager.
// Optional feature macro: SPAWN_EXCLUDE_EN adds player_tile_x/y inputs and
// rejects candidates within one tile of the player as if they were walls.
module powerup_spawn_scheduler #(
   parameter int          NUM_SLOTS      = 3,
   parameter int          SPAWN_INTERVAL = 300,
   parameter int          MAX_RETRIES    = 8,
   parameter int          MAZE_W         = 20,
   parameter int          MAZE_H         = 20,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_tick,
   input  logic                 enable,
   input  logic [NUM_SLOTS-1:0] slot_visible,
`ifdef SPAWN_EXCLUDE_EN
   input  logic [4:0]           player_tile_x,
   input  logic [4:0]           player_tile_y,
`endif
   output logic                 maze_rd_en,
   output logic [4:0]           maze_rd_x,
   output logic [4:0]           maze_rd_y,
   input  logic                 maze_rd_wall,
   output logic                 spawn_valid,
   input  logic                 spawn_ready,
   output logic [1:0]           spawn_slot,
   output logic [4:0]           spawn_tile_x,
   output logic [4:0]           spawn_tile_y,
   output logic [1:0]           spawn_type,
   output logic                 busy,
   output logic [7:0]           fail_count
);

   localparam int CD_W = (SPAWN_INTERVAL < 1) ? 1 : $clog2(SPAWN_INTERVAL + 1);
   localparam int RT_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
   localparam logic [CD_W-1:0] CD_RELOAD = CD_W'(SPAWN_INTERVAL);
   localparam logic [RT_W-1:0] RT_LIMIT  = RT_W'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_PICK  = 3'd2,
      S_READ  = 3'd3,
      S_CHECK = 3'd4,
      S_OFFER = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [15:0]     lfsr_q, lfsr_d;
   logic [CD_W-1:0] cooldown_q, cooldown_d;
   logic [RT_W-1:0] retries_q, retries_d;
   logic [7:0]      fail_q, fail_d;
   logic [4:0]      tile_x_q, tile_x_d, tile_y_q, tile_y_d;
   logic [1:0]      type_q, type_d, slot_q, slot_d;
   logic            rd_en_q, rd_en_d, valid_q, valid_d, busy_q, busy_d;

   logic            free_any_s;
   logic [1:0]      free_idx_s;
   logic [4:0]      cand_x_s, cand_y_s;
   logic [1:0]      cand_type_s;
   logic            in_range_s, excl_s, wall_hit_s;
   logic [RT_W-1:0] retry_inc_s;

`ifdef SPAWN_EXCLUDE_EN
   function automatic logic within_one(input logic [4:0] a, input logic [4:0] b);
      logic [4:0] diff;
      diff = (a >= b) ? (a - b) : (b - a);
      return (diff <= 5'd1);
   endfunction

   assign excl_s = within_one(cand_x_s, player_tile_x) && within_one(cand_y_s, player_tile_y);
`else
   assign excl_s = 1'b0;
`endif

   // Lowest-index free slot; scanning downward lets the lowest index win.
   always_comb begin
      free_any_s = 1'b0;
      free_idx_s = 2'd0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!slot_visible[i]) begin
            free_any_s = 1'b1;
            free_idx_s = 2'(i);
         end else begin
            free_any_s = free_any_s;
         end
      end
   end

   // Candidate tile and type straight from the LFSR; type code 3 folds to speed.
   always_comb begin
      cand_x_s    = lfsr_q[4:0];
      cand_y_s    = lfsr_q[9:5];
      cand_type_s = (lfsr_q[11:10] == 2'd3) ? 2'd0 : lfsr_q[11:10];
      in_range_s  = (int'(cand_x_s) < MAZE_W) && (int'(cand_y_s) < MAZE_H);
      retry_inc_s = retries_q + RT_W'(1);
   end

   // Next-state, counter and output-register computation for the sequencer.
   always_comb begin
      state_d    = state_q;
      lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      cooldown_d = cooldown_q;
      retries_d  = retries_q;
      fail_d     = fail_q;
      tile_x_d   = tile_x_q;
      tile_y_d   = tile_y_q;
      type_d     = type_q;
      slot_d     = slot_q;
      wall_hit_s = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (enable) begin
               cooldown_d = CD_RELOAD;
               state_d    = S_WAIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            // A tick arriving while already at zero is simply ignored.
            if (cooldown_q == '0) begin
               state_d = free_any_s ? S_PICK : S_WAIT;
            end else if (frame_tick) begin
               cooldown_d = cooldown_q - CD_W'(1);
            end else begin
               cooldown_d = cooldown_q;
            end
         end
         S_PICK: begin
            if (!free_any_s) begin
               cooldown_d = '0;
               state_d    = S_WAIT;
            end else if (!in_range_s) begin
               state_d = S_PICK;
            end else if (excl_s) begin
               wall_hit_s = 1'b1;
            end else begin
               tile_x_d = cand_x_s;
               tile_y_d = cand_y_s;
               type_d   = cand_type_s;
               slot_d   = free_idx_s;
               state_d  = S_READ;
            end
         end
         S_READ: begin
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (maze_rd_wall) begin
               wall_hit_s = 1'b1;
            end else begin
               state_d = S_OFFER;
            end
         end
         S_OFFER: begin
            if (spawn_ready) begin
               retries_d  = '0;
               cooldown_d = CD_RELOAD;
               state_d    = S_WAIT;
            end else begin
               state_d = S_OFFER;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Shared retry/give-up path for maze walls and player-exclusion hits.
      if (wall_hit_s) begin
         if (retry_inc_s >= RT_LIMIT) begin
            fail_d     = (fail_q == 8'hFF) ? fail_q : fail_q + 8'd1;
            retries_d  = '0;
            cooldown_d = CD_RELOAD;
            state_d    = S_WAIT;
         end else begin
            retries_d = retry_inc_s;
            state_d   = S_PICK;
         end
      end else begin
         retries_d = retries_d;
      end

      // Dropping enable aborts from anywhere; the failure tally survives.
      if (!enable) begin
         state_d   = S_IDLE;
         retries_d = '0;
         fail_d    = fail_q;
      end else begin
         state_d = state_d;
      end

      rd_en_d = (state_d == S_READ);
      valid_d = (state_d == S_OFFER);
      busy_d  = (state_d != S_IDLE) && (state_d != S_WAIT);
   end

   // State, LFSR, counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         lfsr_q     <= LFSR_SEED;
         cooldown_q <= '0;
         retries_q  <= '0;
         fail_q     <= 8'd0;
         tile_x_q   <= 5'd0;
         tile_y_q   <= 5'd0;
         type_q     <= 2'd0;
         slot_q     <= 2'd0;
         rd_en_q    <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         cooldown_q <= cooldown_d;
         retries_q  <= retries_d;
         fail_q     <= fail_d;
         tile_x_q   <= tile_x_d;
         tile_y_q   <= tile_y_d;
         type_q     <= type_d;
         slot_q     <= slot_d;
         rd_en_q    <= rd_en_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
      end
   end

   assign maze_rd_en   = rd_en_q;
   assign maze_rd_x    = tile_x_q;
   assign maze_rd_y    = tile_y_q;
   assign spawn_valid  = valid_q;
   assign spawn_slot   = slot_q;
   assign spawn_tile_x = tile_x_q;
   assign spawn_tile_y = tile_y_q;
   assign spawn_type   = type_q;
   assign busy         = busy_q;
   assign fail_count   = fail_q;

endmodule

// File: tb/tb_powerup_spawn_scheduler.sv
// Directed self-checking bench for powerup_spawn_scheduler (SPAWN_INTERVAL=4).
// Includes a maze responder with selectable wall patterns and an independent
// LFSR reference used to predict each spawn payload.
module tb_powerup_spawn_scheduler;

   localparam int SI = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       enable = 1'b0;
   logic [2:0] slot_visible = 3'b000;
   logic       maze_rd_en;
   logic [4:0] maze_rd_x, maze_rd_y;
   logic       maze_rd_wall = 1'b0;
   logic       spawn_valid;
   logic       spawn_ready = 1'b0;
   logic [1:0] spawn_slot;
   logic [4:0] spawn_tile_x, spawn_tile_y;
   logic [1:0] spawn_type;
   logic       busy;
   logic [7:0] fail_count;
`ifdef SPAWN_EXCLUDE_EN
   logic [4:0] player_tile_x = 5'd5;
   logic [4:0] player_tile_y = 5'd5;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int wall_mode = 0;
   int rd_cnt = 0;
   int vld_cnt = 0;
   int bad_cnt = 0;
   int rd0, v0;
   logic [15:0] ref_lfsr, h1, h2, h3;
   logic [4:0]  exp_x, exp_y;
   logic [1:0]  exp_t;

   powerup_spawn_scheduler #(.SPAWN_INTERVAL(SI)) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
      .slot_visible(slot_visible),
`ifdef SPAWN_EXCLUDE_EN
      .player_tile_x(player_tile_x), .player_tile_y(player_tile_y),
`endif
      .maze_rd_en(maze_rd_en), .maze_rd_x(maze_rd_x), .maze_rd_y(maze_rd_y),
      .maze_rd_wall(maze_rd_wall), .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
      .spawn_slot(spawn_slot), .spawn_tile_x(spawn_tile_x), .spawn_tile_y(spawn_tile_y),
      .spawn_type(spawn_type), .busy(busy), .fail_count(fail_count)
   );

   always #5 clk = ~clk;

   function automatic logic wall_at(input int mode, input logic [4:0] x, input logic [4:0] y);
      if (mode == 0) return 1'b0;
      if (mode == 1) return 1'b1;
      return !(((x == 5'd5) && (y == 5'd6)) || ((x == 5'd10) && (y == 5'd10)));
   endfunction

   // Maze wall map with a one-cycle registered read.
   always @(posedge clk) begin
      if (maze_rd_en) maze_rd_wall <= wall_at(wall_mode, maze_rd_x, maze_rd_y);
   end

   // Reference LFSR plus three cycles of history (PICK precedes OFFER by 3).
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ref_lfsr <= 16'hACE1; h1 <= 16'hACE1; h2 <= 16'hACE1; h3 <= 16'hACE1;
      end else begin
         ref_lfsr <= {1'b0, ref_lfsr[15:1]} ^ (ref_lfsr[0] ? 16'hB400 : 16'h0000);
         h1 <= ref_lfsr; h2 <= h1; h3 <= h2;
      end
   end

   // Activity counters for reads, offers and forbidden-tile offers.
   always @(posedge clk) begin
      if (maze_rd_en) rd_cnt <= rd_cnt + 1;
      if (spawn_valid) vld_cnt <= vld_cnt + 1;
      if (spawn_valid && spawn_tile_x == 5'd5 && spawn_tile_y == 5'd6) bad_cnt <= bad_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         @(negedge clk);
         frame_tick = 1'b0;
      end
   endtask

   task automatic wait_valid(input string tag, input int budget);
      for (int i = 0; i < budget && !spawn_valid; i++) @(negedge clk);
      chk(tag, 32'(spawn_valid), 32'd1);
   endtask

   task automatic wait_rd(input string tag, input int budget);
      for (int i = 0; i < budget && !maze_rd_en; i++) @(negedge clk);
      chk(tag, 32'(maze_rd_en), 32'd1);
   endtask

   task automatic wait_fail(input string tag, input logic [7:0] target, input int budget);
      for (int i = 0; i < budget && fail_count != target; i++) @(negedge clk);
      chk(tag, 32'(fail_count), 32'(target));
   endtask

   // Called on the first cycle spawn_valid is seen: payload comes from PICK.
   task automatic check_payload(input string tag, input logic [1:0] slot);
      exp_x = h3[4:0];
      exp_y = h3[9:5];
      exp_t = (h3[11:10] == 2'd3) ? 2'd0 : h3[11:10];
      chk({tag, "_slot"}, 32'(spawn_slot), 32'(slot));
      chk({tag, "_x"}, 32'(spawn_tile_x), 32'(exp_x));
      chk({tag, "_y"}, 32'(spawn_tile_y), 32'(exp_y));
      chk({tag, "_type"}, 32'(spawn_type), 32'(exp_t));
   endtask

   task automatic handshake(input string tag);
      spawn_ready = 1'b1;
      @(negedge clk);
      spawn_ready = 1'b0;
      chk(tag, 32'(spawn_valid), 32'd0);
   endtask

   // Enable (or stay enabled) from IDLE and confirm a full SI-tick cooldown.
   task automatic fresh_cooldown(input string tag);
      enable = 1'b1;
      @(negedge clk);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      pulse_ticks(SI - 1);
      rd0 = rd_cnt;
      repeat (20) @(negedge clk);
      chk({tag, "_early"}, 32'(rd_cnt), 32'(rd0));
      pulse_ticks(1);
      wait_rd({tag, "_rd"}, 80);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_rd_en", 32'(maze_rd_en), 32'd0);
      chk("rst_valid", 32'(spawn_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fail", 32'(fail_count), 32'd0);
      chk("rst_xy", 32'({maze_rd_x, maze_rd_y}), 32'd0);
      chk("rst_payload", 32'({spawn_slot, spawn_tile_x, spawn_tile_y, spawn_type}), 32'd0);
      reset = 1'b0;
      enable = 1'b1;
      @(negedge clk);

      // Basic spawn, payload hold under back-pressure, handshake
      pulse_ticks(SI);
      wait_valid("t2_valid", 80);
      check_payload("t2", 2'd0);
      chk("t2_range", 32'((spawn_tile_x < 5'd20) && (spawn_tile_y < 5'd20) && (spawn_type <= 2'd2)), 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t2_hold", 32'({spawn_valid, spawn_slot, spawn_tile_x, spawn_tile_y, spawn_type}),
             32'({1'b1, 2'd0, exp_x, exp_y, exp_t}));
      end
      handshake("t2_drop");

      // Abort during READ
      pulse_ticks(SI);
      wait_rd("t5_rd", 80);
      enable = 1'b0;
      @(negedge clk);
      chk("t5a_abort", 32'({maze_rd_en, spawn_valid, busy}), 32'd0);
      fresh_cooldown("t5a");
      wait_valid("t5a_valid", 10);
      check_payload("t5a", 2'd0);
      // Abort during OFFER
      enable = 1'b0;
      @(negedge clk);
      chk("t5b_abort", 32'({maze_rd_en, spawn_valid, busy}), 32'd0);
      fresh_cooldown("t5b");
      wait_valid("t5b_valid", 10);
      handshake("t5b_drop");

      // All slots full, then slots free up
      slot_visible = 3'b111;
      pulse_ticks(SI);
      rd0 = rd_cnt;
      repeat (100) @(negedge clk);
      chk("t4_noread", 32'(rd_cnt), 32'(rd0));
      chk("t4_idlebusy", 32'(busy), 32'd0);
      slot_visible = 3'b101;
      wait_valid("t4a_valid", 80);
      check_payload("t4a", 2'd1);
      handshake("t4a_drop");
      slot_visible = 3'b010;
      pulse_ticks(SI);
      wait_valid("t4b_valid", 80);
      check_payload("t4b", 2'd0);
      handshake("t4b_drop");
      slot_visible = 3'b000;

      // All-wall maze: bounded retries, fail count, cooldown reload, saturation
      wall_mode = 1;
      rd0 = rd_cnt;
      v0 = vld_cnt;
      pulse_ticks(SI);
      wait_fail("t3_fail1", 8'd1, 1000);
      chk("t3_reads", 32'(rd_cnt - rd0), 32'd8);
      chk("t3_novalid", 32'(vld_cnt), 32'(v0));
      pulse_ticks(SI - 1);
      rd0 = rd_cnt;
      repeat (20) @(negedge clk);
      chk("t3_reload", 32'(rd_cnt), 32'(rd0));
      pulse_ticks(1);
      wait_rd("t3_rd_again", 80);
      frame_tick = 1'b1;
      wait_fail("t3_fail255", 8'd255, 40000);
      repeat (600) @(negedge clk);
      chk("t3_sat", 32'(fail_count), 32'd255);
      chk("t3_novalid_all", 32'(vld_cnt), 32'(v0));

      // Reset asserted mid-OFFER
      wall_mode = 0;
      wait_valid("t1_valid", 400);
      frame_tick = 1'b0;
      repeat (2) @(negedge clk);
      chk("t1_held", 32'(spawn_valid), 32'd1);
      reset = 1'b1;
      #1;
      chk("t1_rst_out", 32'({maze_rd_en, spawn_valid, busy}), 32'd0);
      chk("t1_rst_fail", 32'(fail_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      fresh_cooldown("t1");
      wait_valid("t1_valid2", 10);
      check_payload("t1", 2'd0);
      handshake("t1_drop");

`ifdef SPAWN_EXCLUDE_EN
      // Player exclusion: only (10,10) is a legal spawn
      wall_mode = 2;
      frame_tick = 1'b1;
      wait_valid("t6_valid", 60000);
      frame_tick = 1'b0;
      chk("t6_x", 32'(spawn_tile_x), 32'd10);
      chk("t6_y", 32'(spawn_tile_y), 32'd10);
      chk("t6_never56", 32'(bad_cnt), 32'd0);
      handshake("t6_drop");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/powerup_spawn_scheduler.md
Name: powerup_spawn_scheduler

Overview:
Sequences powerup spawning for the maze game.
- Paces spawn attempts with a frame-based cooldown.
- Draws candidate tiles from an internal LFSR and probes the maze wall map through a registered read port.
- Retries when the candidate tile is a wall, up to a bounded count.
- Issues one spawn command per success to the powerup manager over a valid/ready handshake, targeting the lowest free slot.

Parameters:
NUM_SLOTS, 3, number of powerup slots in the manager
SPAWN_INTERVAL, 300, frame_ticks between spawn attempts
MAX_RETRIES, 8, maze probes per attempt before giving up
MAZE_W, 20, maze width in tiles (must be ≤32)
MAZE_H, 20, maze height in tiles (must be ≤32)
LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
enable  in  1  game running; low aborts and idles
slot_visible  in  NUM_SLOTS  bit i high = slot i occupied
maze_rd_en  out  1  maze wall read request
maze_rd_x  out  5  tile column to read
maze_rd_y  out  5  tile row to read
maze_rd_wall  in  1  wall bit; valid exactly 1 cycle after maze_rd_en
spawn_valid  out  1  spawn command valid
spawn_ready  in  1  manager accepts command
spawn_slot  out  2  target slot index
spawn_tile_x  out  5  tile column
spawn_tile_y  out  5  tile row
spawn_type  out  2  0 speed, 1 wallPhase, 2 triple
busy  out  1  high in any state except IDLE and WAIT
fail_count  out  8  saturating count of failed attempts

Behaviour:
- Reset: state IDLE; LFSR = LFSR_SEED; cooldown = 0; retries = 0; fail_count = 0.
  - All outputs are 0 in reset: maze_rd_en, spawn_valid, maze_rd_x/y, spawn_slot, spawn_tile_x/y, spawn_type, busy.
- LFSR: 16-bit Galois, polynomial mask 16'hB400, shifted right every clk regardless of state.
- States: IDLE, WAIT, PICK, READ, CHECK, OFFER.
  - IDLE: when enable=1, load cooldown = SPAWN_INTERVAL and go to WAIT.
  - WAIT: each frame_tick decrements cooldown; it saturates at 0.
    - Exit to PICK when cooldown==0 and at least one slot_visible bit is 0.
    - If all slots are full, remain in WAIT with cooldown held at 0; spawn fires the first cycle a slot frees.
  - PICK:
    - Candidate x = lfsr[4:0], y = lfsr[9:5].
    - If x ≥ MAZE_W or y ≥ MAZE_H, stay in PICK for the next cycle (rejection; not counted as a retry).
    - Otherwise latch x, y, and type (lfsr[11:10], with 3 mapped to 0), then go to READ.
    - Latch free slot = lowest index with slot_visible=0. If none is free (slot taken meanwhile), return to WAIT with cooldown 0.
  - READ: maze_rd_en=1 for exactly one cycle with latched x/y; go to CHECK.
  - CHECK: sample maze_rd_wall.
    - If 0: go to OFFER.
    - If 1: retries++. If retries < MAX_RETRIES, go to PICK. Otherwise fail_count++ (saturating at 255), clear retries, reload cooldown = SPAWN_INTERVAL, go to WAIT.
  - OFFER: spawn_valid=1; slot, tile, and type held stable until spawn_ready.
    - On the spawn_valid & spawn_ready cycle: clear retries, reload cooldown, go to WAIT; spawn_valid=0 the next cycle.
- enable=0 in any state: next state IDLE; spawn_valid and maze_rd_en deassert the next cycle; retries cleared; fail_count kept.
  - This abort is the only case in which spawn_valid may drop without a handshake.
- frame_tick coinciding with the WAIT exit cycle is ignored (no underflow).
- maze_rd_x/y hold their last value when maze_rd_en=0.
- Latency, open maze, in-range LFSR candidate: cooldown expiry to spawn_valid is 4 cycles (WAIT→PICK→READ→CHECK→OFFER).

Optional Feature:
SPAWN_EXCLUDE_EN:
- When defined, adds input ports player_tile_x[4:0] and player_tile_y[4:0].
- A candidate in PICK with |x−player_tile_x| ≤ 1 and |y−player_tile_y| ≤ 1 is treated as a wall: no maze read, retries++, same retry/fail rules as CHECK.
- When undefined, the ports are absent and no exclusion check is made.

Test Plan:
1. Assert reset mid-OFFER (valid high, ready low) -> same cycle: spawn_valid=0, maze_rd_en=0, busy=0, fail_count=0; after release with enable=1, state WAIT with full interval.
2. SPAWN_INTERVAL=4, open maze, slot_visible=000, enable=1, 4 frame_ticks -> spawn_valid within 4 cycles of the 4th tick plus PICK rejections, spawn_slot=0, tile in range (x<20, y<20), type ≤2; hold spawn_ready=0 for 10 cycles -> payload unchanged; ready=1 -> valid low next cycle.
3. All-wall maze, MAX_RETRIES=8 -> exactly 8 maze_rd_en pulses, no spawn_valid, fail_count=1, cooldown reloaded to 4; repeat 300 attempts -> fail_count=255.
4. slot_visible=111 with cooldown expired -> no maze reads for 100 cycles; clear bit 1 -> next spawn_slot=1; clear bits 0 and 2 -> spawn_slot=0.
5. Drop enable during READ, and again during OFFER -> next cycle maze_rd_en=0, spawn_valid=0, busy=0; re-enable -> fresh 4-tick cooldown.
6. SPAWN_EXCLUDE_EN, player at (5,5), wall tiles everywhere except (5,6) and (10,10) -> every spawn lands at (10,10), never at (5,6).
